// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART RX controller: FWFT byte queue with framing-error tag,
// occupancy flags and sticky overrun. Define UART_RX_FIFO_OVR_CNT_EN for the dropped-byte counter.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_frame_err,
  input  logic                  wr_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_frame_err,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  input  logic                  flush,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty,
  output logic                  overrun,
  input  logic                  overrun_clr,
  output logic [7:0]            overrun_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count_q;
  logic                push;
  logic                pop;
  logic                drop;

  assign count    = count_q;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign rd_valid = !empty;

  // A full FIFO still accepts a byte when the head leaves in the same cycle; flush swallows everything.
  assign pop  = rd_valid && rd_ready;
  assign push = wr_valid && (!full || pop) && !flush;
  assign drop = wr_valid && full && !pop && !flush;

  assign {rd_frame_err, rd_data} = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {wr_frame_err, wr_data};
  end

  // A new drop outranks a clear request in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)         overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
    else if (overrun_clr) overrun <= 1'b0;
  end

`ifdef UART_RX_FIFO_OVR_CNT_EN
  logic [7:0] ovr_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                    ovr_cnt <= 8'd0;
    else if (overrun_clr)            ovr_cnt <= drop ? 8'd1 : 8'd0;
    else if (drop && ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
  end

  assign overrun_count = ovr_cnt;
`else
  assign overrun_count = 8'd0;
`endif

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART RX datapath/controller. Captures each completed byte together with its framing-error status when the receiver pulses wr_valid.
- Presents received bytes to the host/bus side through a first-word-fall-through valid/ready interface.
- Tracks occupancy and flags overrun when the receiver delivers a byte while the buffer is full.

Parameters:
- DATA_WIDTH, 8, width of each received character (matches receiver DATA_WIDTH)
- DEPTH, 16, number of entries; power of two, >= 2
- CNT_W, $clog2(DEPTH)+1, occupancy width (localparam, not overridable)

Ports:
- clock  input  1  single system clock; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- wr_data  input  DATA_WIDTH  byte from receiver shift register
- wr_frame_err  input  1  stop bit sampled low for this byte
- wr_valid  input  1  one-cycle pulse, byte complete; no backpressure to receiver
- rd_data  output  DATA_WIDTH  head-of-queue byte
- rd_frame_err  output  1  framing-error flag stored with head byte
- rd_valid  output  1  head entry valid
- rd_ready  input  1  consumer accepts head when rd_valid high
- flush  input  1  synchronous discard of all entries
- count  output  CNT_W  current occupancy, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- overrun  output  1  sticky: a byte was dropped
- overrun_clr  input  1  synchronous clear of overrun
- overrun_count  output  8  dropped-byte counter (see Optional Feature)

Behaviour:
- Reset (reset_n low, asynchronous): write/read pointers = 0, count = 0, empty = 1, full = 0, rd_valid = 0, overrun = 0, overrun_count = 0. rd_data/rd_frame_err = 0 while empty.
- Storage: DEPTH x (DATA_WIDTH+1) array holding {frame_err, data}. Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0.
- Push: wr_valid && (!full || pop). Writes the entry at wr_ptr and increments wr_ptr.
- Pop: rd_valid && rd_ready. Increments rd_ptr.
- FWFT timing:
  - rd_valid = !empty, combinational from count.
  - rd_data/rd_frame_err = mem[rd_ptr].
  - A byte pushed into an empty FIFO in cycle N appears with rd_valid high in cycle N+1.
- Count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full with simultaneous push and pop: both occur; count stays DEPTH; no overrun.
- Empty with wr_valid: push occurs; no pop is possible because rd_valid is low.
- Overrun: wr_valid && full && !pop. Byte is dropped, storage and pointers are unchanged, overrun <= 1.
- overrun_clr clears overrun next cycle. If overrun_clr and a new overrun event occur in the same cycle, the set wins.
- Flush (synchronous, highest priority over push/pop):
  - Pointers = 0, count = 0 next cycle.
  - A push in the same cycle is discarded and does not count as overrun.
  - overrun and overrun_count are unaffected.
- rd_ready while rd_valid low: no effect.
- Reset mid-operation: all contents lost immediately. No partial-state retention.

Optional Feature:
- Macro: UART_RX_FIFO_OVR_CNT_EN.
- Defined: overrun_count is an 8-bit saturating counter.
  - Increments on every dropped byte and holds at 255.
  - Cleared by overrun_clr; if a drop coincides with overrun_clr, the result is 1.
- Undefined: no counter logic; overrun_count tied to 0. The sticky overrun flag behaves identically in both builds.

Test Plan:
- Reset, then push 0xA5 (frame_err=0) -> next cycle rd_valid=1, rd_data=0xA5, count=1, empty=0. Pop -> empty=1, count=0.
- Push 16 bytes 0x00..0x0F with rd_ready=0 -> full=1, count=16. Drain -> bytes read in order 0x00..0x0F, then empty=1.
- Fill to 16, push 0xEE with no pop -> overrun=1, count=16, 0xEE never read. With macro, overrun_count=1. overrun_clr -> overrun=0.
- Full, then push 0x55 with rd_ready=1 in the same cycle -> head popped, 0x55 stored as last entry, count=16, overrun=0.
- Push 0x3C with wr_frame_err=1, then 0x3D with 0 -> rd_frame_err=1 on first read, 0 on second.
- Load 5 entries with overrun=1, then assert flush together with wr_valid -> count=0, empty=1, overrun still 1. Assert reset_n low mid-stream -> all outputs at reset values immediately.
